// File: rtl/atm_balance_ledger_if.sv
// Handshake/bus bundle between the ATM front panel logic and the balance ledger.
// The ledger uses the slave view; whoever drives buttons and switches uses master.
`timescale 1ns/1ps
interface atm_balance_ledger_if #(
  parameter int unsigned WIDTH = 8
);
  logic             dep_btn;
  logic             wd_btn;
  logic [WIDTH-1:0] amount;
  logic             amount_ok;
  logic [WIDTH-1:0] balance;
  logic             err_over;
  logic             err_funds;
  logic             busy;
  logic             txn_done;
  logic [7:0]       txn_count;

  modport master (
    output dep_btn, wd_btn, amount, amount_ok,
    input  balance, err_over, err_funds, busy, txn_done, txn_count
  );

  modport slave (
    input  dep_btn, wd_btn, amount, amount_ok,
    output balance, err_over, err_funds, busy, txn_done, txn_count
  );
endinterface

// File: rtl/atm_balance_ledger.sv
// Account balance keeper: one committed deposit/withdraw per button press,
// with overflow and insufficient-funds rejection and timed error flags.
`timescale 1ns/1ps
module atm_balance_ledger #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned INIT_BAL = 0,
  parameter int unsigned MAX_BAL  = 255,
  parameter int unsigned ERR_HOLD = 50000000
) (
  input  logic                  clk,
  input  logic                  reset,
  atm_balance_ledger_if.slave   bus
);

  localparam int unsigned HOLD_W = (ERR_HOLD > 1) ? $clog2(ERR_HOLD) : 1;

  typedef enum logic [2:0] {IDLE, LATCH, CHECK, COMMIT, ERROR, RELEASE} state_t;

  state_t            state_reg, state_next;
  logic              dep_cur_reg, dep_prev_reg, wd_cur_reg, wd_prev_reg;
  logic              op_wd_reg;
  logic [WIDTH-1:0]  amt_reg;
  logic              amt_ok_reg;
  logic [WIDTH-1:0]  result_reg;
  logic [WIDTH-1:0]  balance_reg;
  logic              err_over_reg, err_funds_reg;
  logic [HOLD_W-1:0] hold_reg;
  logic              txn_done_reg;
  logic [7:0]        txn_count_reg;

  logic              dep_rise, wd_rise;
  logic [WIDTH:0]    sum;
  logic              dep_bad, wd_bad, check_fail, hold_done;

  assign dep_rise   = dep_cur_reg & ~dep_prev_reg;
  assign wd_rise    = wd_cur_reg & ~wd_prev_reg;
  // Sum carries an extra bit so a wrap past 2^WIDTH is still seen as overflow.
  assign sum        = {1'b0, balance_reg} + {1'b0, amt_reg};
  assign dep_bad    = (sum > (WIDTH+1)'(MAX_BAL)) || !amt_ok_reg;
  assign wd_bad     = (amt_reg > balance_reg) || !amt_ok_reg;
  assign check_fail = op_wd_reg ? wd_bad : dep_bad;
  assign hold_done  = (hold_reg == HOLD_W'(ERR_HOLD - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (dep_rise && wd_rise)     state_next = RELEASE;
        else if (dep_rise || wd_rise) state_next = LATCH;
      end
      LATCH:   state_next = CHECK;
      CHECK:   state_next = check_fail ? ERROR : COMMIT;
      COMMIT:  state_next = RELEASE;
      ERROR:   if (hold_done) state_next = RELEASE;
      RELEASE: if (!dep_cur_reg && !wd_cur_reg) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dep_cur_reg   <= 1'b0;
      dep_prev_reg  <= 1'b0;
      wd_cur_reg    <= 1'b0;
      wd_prev_reg   <= 1'b0;
      op_wd_reg     <= 1'b0;
      amt_reg       <= '0;
      amt_ok_reg    <= 1'b0;
      result_reg    <= '0;
      balance_reg   <= WIDTH'(INIT_BAL);
      err_over_reg  <= 1'b0;
      err_funds_reg <= 1'b0;
      hold_reg      <= '0;
      txn_done_reg  <= 1'b0;
      txn_count_reg <= 8'd0;
    end else begin
      dep_cur_reg  <= bus.dep_btn;
      dep_prev_reg <= dep_cur_reg;
      wd_cur_reg   <= bus.wd_btn;
      wd_prev_reg  <= wd_cur_reg;
      txn_done_reg <= 1'b0;
      case (state_reg)
        IDLE: if (state_next == LATCH) op_wd_reg <= wd_rise;
        LATCH: begin
          amt_reg    <= bus.amount;
          amt_ok_reg <= bus.amount_ok;
        end
        CHECK: begin
          result_reg <= op_wd_reg ? (balance_reg - amt_reg) : sum[WIDTH-1:0];
          hold_reg   <= '0;
          if (check_fail) begin
            if (op_wd_reg) err_funds_reg <= 1'b1;
            else           err_over_reg  <= 1'b1;
          end
        end
        COMMIT: begin
          balance_reg   <= result_reg;
          txn_done_reg  <= 1'b1;
          txn_count_reg <= txn_count_reg + 8'd1;
        end
        ERROR: begin
          if (hold_done) begin
            err_over_reg  <= 1'b0;
            err_funds_reg <= 1'b0;
            hold_reg      <= '0;
          end else begin
            hold_reg <= hold_reg + HOLD_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.balance   = balance_reg;
  assign bus.err_over  = err_over_reg;
  assign bus.err_funds = err_funds_reg;
  assign bus.busy      = (state_reg != IDLE);
  assign bus.txn_done  = txn_done_reg;
  assign bus.txn_count = txn_count_reg;

endmodule

// File: tb/tb_atm_balance_ledger.sv
// Scoreboard bench for the balance ledger: each press pushes its expected outcome,
// a negedge monitor pops and compares when txn_done or an error flag appears.
`timescale 1ns/1ps
module tb_atm_balance_ledger;
  localparam int W    = 8;
  localparam int HOLD = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  atm_balance_ledger_if #(.WIDTH(W)) bus();

  atm_balance_ledger #(
    .WIDTH(W), .INIT_BAL(0), .MAX_BAL(255), .ERR_HOLD(HOLD)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  // kind: 0 = commit, 1 = err_over, 2 = err_funds
  typedef struct {
    int kind;
    int bal;
    int cnt;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;
  int m_bal = 0;
  int m_cnt = 0;
  logic ov_prev = 1'b0;
  logic fu_prev = 1'b0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (bus.txn_done) begin
        if (sb.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = sb.pop_front();
          chk("done_kind", 0, e.kind);
          chk("done_bal", int'(bus.balance), e.bal);
          chk("done_count", int'(bus.txn_count), e.cnt);
        end
      end
      if ((bus.err_over && !ov_prev) || (bus.err_funds && !fu_prev)) begin
        if (sb.size() == 0) chk("unexpected_err", 1, 0);
        else begin
          e = sb.pop_front();
          chk("err_kind", bus.err_over ? 1 : 2, e.kind);
          chk("err_bal", int'(bus.balance), e.bal);
        end
      end
      if (bus.err_over && bus.err_funds) chk("one_err_flag", 1, 0);
    end
    ov_prev = bus.err_over;
    fu_prev = bus.err_funds;
  end

  // One button press; change_at > 0 rewrites amount to 99 on that negedge.
  task automatic do_txn(input bit wd, input int amt, input bit ok,
                        input int hold_cyc, input int change_at);
    exp_t e;
    int done_at, err_cyc, pulses;
    if (!wd) begin
      if (m_bal + amt > 255 || !ok) e.kind = 1;
      else begin e.kind = 0; m_bal = m_bal + amt; end
    end else begin
      if (amt > m_bal || !ok) e.kind = 2;
      else begin e.kind = 0; m_bal = m_bal - amt; end
    end
    if (e.kind == 0) m_cnt = (m_cnt + 1) % 256;
    e.bal = m_bal;
    e.cnt = m_cnt;
    sb.push_back(e);
    bus.amount    = W'(amt);
    bus.amount_ok = ok;
    @(posedge clk); #1;
    if (wd) bus.wd_btn = 1'b1;
    else    bus.dep_btn = 1'b1;
    done_at = 0; err_cyc = 0; pulses = 0;
    for (int k = 1; k <= hold_cyc + 60; k++) begin
      @(negedge clk);
      if (bus.txn_done) begin
        pulses++;
        if (done_at == 0) done_at = k;
      end
      if (bus.err_over || bus.err_funds) err_cyc++;
      if (k == change_at) bus.amount = W'(99);
      if (k == hold_cyc) begin
        bus.dep_btn = 1'b0;
        bus.wd_btn  = 1'b0;
      end
      if (k > hold_cyc && !bus.busy) break;
    end
    chk("returned_idle", int'(bus.busy), 0);
    chk("done_pulses", pulses, (e.kind == 0) ? 1 : 0);
    chk("err_length", err_cyc, (e.kind == 0) ? 0 : HOLD);
    if (e.kind == 0) chk("commit_latency", done_at, 6);
    chk("balance_after", int'(bus.balance), m_bal);
    $display("txn %s amt=%0d ok=%0d -> kind=%0d balance=%0d count=%0d",
             wd ? "wd " : "dep", amt, ok, e.kind, bus.balance, bus.txn_count);
  endtask

  initial begin : stim
    int pulses;
    bus.dep_btn = 1'b0; bus.wd_btn = 1'b0;
    bus.amount = '0; bus.amount_ok = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_balance", int'(bus.balance), 0);
    chk("rst_count", int'(bus.txn_count), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_flags", int'({bus.err_over, bus.err_funds, bus.txn_done}), 0);
    rst = 1'b0;
    $display("reset released");

    do_txn(0, 20, 1, 3, 0);
    do_txn(1, 30, 1, 3, 0);
    do_txn(1, 20, 1, 3, 0);
    do_txn(0, 250, 1, 3, 0);
    do_txn(0, 10, 1, 3, 0);
    do_txn(0, 5, 1, 3, 0);
    do_txn(0, 0, 1, 100, 0);

    // Both buttons in the same cycle: parked in RELEASE, nothing commits.
    @(posedge clk); #1;
    bus.dep_btn = 1'b1; bus.wd_btn = 1'b1;
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.txn_done) pulses++;
    end
    chk("both_busy", int'(bus.busy), 1);
    chk("both_pulses", pulses, 0);
    chk("both_count", int'(bus.txn_count), m_cnt);
    bus.dep_btn = 1'b0; bus.wd_btn = 1'b0;
    repeat (3) @(negedge clk);
    chk("both_idle", int'(bus.busy), 0);
    $display("txn both-buttons -> ignored balance=%0d", bus.balance);

    do_txn(1, 20, 1, 5, 4);
    do_txn(1, 10, 0, 3, 0);
    do_txn(0, 5, 0, 3, 0);

    // Reset while the FSM sits in CHECK.
    bus.amount = W'(7); bus.amount_ok = 1'b1;
    @(posedge clk); #1;
    bus.dep_btn = 1'b1;
    repeat (4) @(negedge clk);
    chk("pre_reset_busy", int'(bus.busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_balance", int'(bus.balance), 0);
    chk("midrst_count", int'(bus.txn_count), 0);
    chk("midrst_flags", int'({bus.err_over, bus.err_funds, bus.txn_done, bus.busy}), 0);
    bus.dep_btn = 1'b0;
    rst = 1'b0;
    m_bal = 0; m_cnt = 0;
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.txn_done) pulses++;
    end
    chk("midrst_no_done", pulses, 0);
    $display("txn reset-in-check -> aborted balance=%0d", bus.balance);

    for (int i = 0; i < 256; i++) do_txn(0, 0, 1, 3, 0);
    chk("count_wrap", int'(bus.txn_count), 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
